// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_arb_pkg
// Desc     : Shared types and constants for the bus_arbiter block: FSM state
//            encoding, destination-ID field width and default broadcast ID.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    // Width of the destination-ID field carried in the top bits of each word
    localparam int unsigned c_id_w = 8;

    // Destination ID that addresses every terminal except the sender
    localparam logic [7:0] c_broadcast_default = 8'hFF;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Desc     : Combinational round-robin selector. Searches the request vector
//            starting at the entry after i_last_grant, wrapping N-1 -> 0, and
//            returns the first active index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_valid
);

    int w_idx;

    // Scan from the farthest candidate to the nearest so the nearest active
    // requester after i_last_grant is the one that sticks.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = int'(i_last_grant) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (i_req[IDX_W'(w_idx)]) begin
                o_grant = IDX_W'(w_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Desc     : Shared-bus arbiter. Picks a pending terminal round-robin, pops its
//            head word (POP), then pushes it to the destination terminal, to
//            all other terminals on broadcast, or drops it (PUSH).
// Config   : define BUS_ARB_DROP_CNT_EN to add the saturating drop_cnt_o port.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int         DRIVERS   = 4,
    parameter int         WIDTH     = 32,
    parameter logic [7:0] BROADCAST = c_broadcast_default
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [DRIVERS-1:0]              pndng_i,
    input  logic [DRIVERS-1:0][WIDTH-1:0]   d_pop_i,
    output logic [DRIVERS-1:0]              pop_o,
    output logic [DRIVERS-1:0]              push_o,
    output logic [WIDTH-1:0]                d_push_o,
    output logic                            busy_o
`ifdef BUS_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                     drop_cnt_o
`endif
);

    localparam int               c_idx_w = $clog2(DRIVERS);
    localparam logic [DRIVERS-1:0] c_one = DRIVERS'(1);

    state_t                 r_state;
    logic [c_idx_w-1:0]     r_grant;
    logic [c_idx_w-1:0]     r_last_grant;
    logic [WIDTH-1:0]       r_word;
    logic [DRIVERS-1:0]     r_pop;
    logic [DRIVERS-1:0]     r_push;

    logic [c_idx_w-1:0]     w_arb_grant;
    logic                   w_arb_valid;
    logic [WIDTH-1:0]       w_head;
    logic [c_id_w-1:0]      w_dest;
    logic                   w_is_bcast;
    logic [DRIVERS-1:0]     w_push_vec;

    rr_arbiter #(
        .N      (DRIVERS),
        .IDX_W  (c_idx_w)
    ) u_rr_arbiter (
        .i_req        (pndng_i),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_valid      (w_arb_valid)
    );

    // Head word of the granted terminal and its destination field
    assign w_head     = d_pop_i[r_grant];
    assign w_dest     = w_head[WIDTH-1 -: c_id_w];
    assign w_is_bcast = (w_dest == BROADCAST);

    // Destination decode: broadcast hits everyone but the sender; unicast
    // hits only a matching in-range ID; anything else decodes to zero (drop).
    for (genvar i = 0; i < DRIVERS; i++) begin : g_push_dec
        assign w_push_vec[i] = w_is_bcast ? (r_grant != c_idx_w'(i))
                                          : (w_dest == c_id_w'(i));
    end

    // Main FSM: arbitration, pop strobe, word capture and push strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_idx_w'(DRIVERS - 1);
            r_word       <= '0;
            r_pop        <= '0;
            r_push       <= '0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            case (r_state)
                // PUSH re-arbitrates directly so back-to-back words take 2 cycles
                IDLE, PUSH: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_grant;
                        r_pop   <= c_one << w_arb_grant;
                        r_state <= POP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                POP: begin
                    r_word       <= w_head;
                    r_last_grant <= r_grant;
                    r_push       <= w_push_vec;
                    r_state      <= PUSH;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pop_o    = r_pop;
    assign push_o   = r_push;
    assign d_push_o = r_word;
    assign busy_o   = (r_state != IDLE);

`ifdef BUS_ARB_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = !w_is_bcast && (w_dest >= c_id_w'(DRIVERS));

    // Saturating count of words discarded for an out-of-range destination
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if ((r_state == POP) && w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Desc     : Self-checking bench for bus_arbiter: terminal FIFO model, push
//            scoreboard, table of single-word transfers and hand sequences
//            for latency, round-robin order and reset during PUSH.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [N-1:0]         pndng;
    logic [N-1:0][W-1:0]  d_pop;
    logic [N-1:0]         pop;
    logic [N-1:0]         push;
    logic [W-1:0]         d_push;
    logic                 busy;
`ifdef BUS_ARB_DROP_CNT_EN
    logic [15:0]          drop_cnt;
`endif

    always #5 clk = ~clk;

    bus_arbiter #(
        .DRIVERS   (N),
        .WIDTH     (W),
        .BROADCAST (8'hFF)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .pndng_i    (pndng),
        .d_pop_i    (d_pop),
        .pop_o      (pop),
        .push_o     (push),
        .d_push_o   (d_push),
        .busy_o     (busy)
`ifdef BUS_ARB_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt)
`endif
    );

    typedef struct {
        int          src;
        logic [31:0] word;
        logic [3:0]  exp_push;
    } vec_t;

    typedef struct {
        logic [3:0]  vec;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] mem [N][8];
    int          head [N];
    int          cnt  [N];
    int          pop_log[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          push_seen = 0;
    logic [3:0]  s_pop;
    logic [3:0]  s_push;
    logic [31:0] s_d;
    logic        s_busy;
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Present each terminal FIFO head and not-empty flag
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (cnt[i] != 0);
            d_pop[i] = (cnt[i] != 0) ? mem[i][head[i]] : 32'h0;
        end
    endtask

    task automatic load(input int src, input logic [31:0] w);
        mem[src][(head[src] + cnt[src]) % 8] = w;
        cnt[src]++;
        drive();
    endtask

    task automatic expect_push(input logic [3:0] v, input logic [31:0] d);
        exp_t e;
        e.vec  = v;
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic bit fifos_empty();
        bit r;
        r = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] != 0) r = 1'b0;
        end
        return r;
    endfunction

    // One clock: sample/check outputs at negedge, then advance the FIFO model
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_pop  = pop;
        s_push = push;
        s_d    = d_push;
        s_busy = busy;
        chk("pop_push_overlap", 32'((|s_pop) & (|s_push)), 32'd0);
        chk("pop_onehot0", 32'($onehot0(s_pop)), 32'd1);
        if (|s_push) begin
            push_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_push", 32'(s_push), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("push_vec", 32'(s_push), 32'(e.vec));
                chk("push_data", s_d, e.data);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_pop[i]) begin
                pop_log.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_pop[i] && cnt[i] > 0) begin
                head[i] = (head[i] + 1) % 8;
                cnt[i]--;
            end
        end
        drive();
    endtask

    task automatic run_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            done = fifos_empty() && !s_busy && (sb.size() == 0);
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_drops;
        logic [31:0] w;

        vecs[0] = '{1, 32'h0200_0005, 4'b0100};
        vecs[1] = '{2, 32'hFF00_00AA, 4'b1011};
        vecs[2] = '{0, 32'h0900_0001, 4'b0000};
        vecs[3] = '{3, 32'h0300_0007, 4'b1000};
        vecs[4] = '{0, 32'h0100_1234, 4'b0010};
        vecs[5] = '{3, 32'h0000_BEEF, 4'b0001};
        vecs[6] = '{1, 32'hFF12_3456, 4'b1101};
        vecs[7] = '{0, 32'h0400_0000, 4'b0000};
        vecs[8] = '{2, 32'h0300_0000, 4'b1000};
        vecs[9] = '{0, 32'hFE00_0001, 4'b0000};

        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        rst_ni = 1'b0;
        pndng  = '0;
        d_pop  = '0;

        // Reset state
        #3;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", d_push, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Latency: pop in cycle 2, push in cycle 3
        expect_push(4'b0100, 32'h0200_0005);
        load(1, 32'h0200_0005);
        step();
        chk("lat_c1_pop", 32'(s_pop), 32'd0);
        chk("lat_c1_busy", 32'(s_busy), 32'd0);
        step();
        chk("lat_c2_pop", 32'(s_pop), 32'h2);
        chk("lat_c2_busy", 32'(s_busy), 32'd1);
        step();
        chk("lat_c3_push", 32'(s_push), 32'h4);
        chk("lat_c3_data", s_d, 32'h0200_0005);
        run_idle(10);

        // Table of single-word transfers
        for (int r = 0; r < 10; r++) begin
            pop_log.delete();
            pop_cyc.delete();
            push_seen = 0;
            if (vecs[r].exp_push != 4'b0000) expect_push(vecs[r].exp_push, vecs[r].word);
            load(vecs[r].src, vecs[r].word);
            run_idle(10);
            chk($sformatf("row%0d_pops", r), 32'(pop_log.size()), 32'd1);
            if (pop_log.size() >= 1) chk($sformatf("row%0d_grant", r), 32'(pop_log[0]), 32'(vecs[r].src));
            chk($sformatf("row%0d_pushes", r), 32'(push_seen), 32'(vecs[r].exp_push != 4'b0000));
        end

        exp_drops = 0;
        for (int r = 0; r < 10; r++) begin
            if (vecs[r].exp_push == 4'b0000) exp_drops++;
        end
`ifdef BUS_ARB_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

        // Round-robin order with every terminal pending
        rst_ni = 1'b0;
        #2;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        pop_log.delete();
        pop_cyc.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                w = {8'((i + 1) % N), 16'h0000, 8'(i * 16 + k)};
                expect_push(4'(1) << ((i + 1) % N), w);
                load(i, w);
            end
        end
        run_idle(40);
        chk("rr_pop_count", 32'(pop_log.size()), 32'd8);
        for (int j = 0; j < pop_log.size(); j++) begin
            chk($sformatf("rr_grant%0d", j), 32'(pop_log[j]), 32'(j % N));
            if (j > 0) chk($sformatf("rr_spacing%0d", j), 32'(pop_cyc[j] - pop_cyc[j-1]), 32'd2);
        end

        // Reset asserted during PUSH aborts and restarts arbitration at 0
        load(1, 32'h0200_0033);
        step();
        step();
        chk("mid_push_active", 32'(push), 32'h4);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_push", 32'(push), 32'd0);
        chk("mid_rst_pop", 32'(pop), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", d_push, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        pop_log.delete();
        pop_cyc.delete();
        expect_push(4'b1000, 32'h0300_0011);
        expect_push(4'b0010, 32'h0100_0022);
        load(0, 32'h0300_0011);
        load(2, 32'h0100_0022);
        step();
        chk("post_rst_busy", 32'(s_busy), 32'd0);
        chk("post_rst_pop", 32'(s_pop), 32'd0);
        run_idle(20);
        chk("post_rst_pops", 32'(pop_log.size()), 32'd2);
        if (pop_log.size() == 2) begin
            chk("post_rst_first", 32'(pop_log[0]), 32'd0);
            chk("post_rst_second", 32'(pop_log[1]), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
